ir_key_decoder: RTL and testbench
=================================

// Module: ir_key_decoder
// PURPOSE
//  Consumes 32-bit NEC frames from the IR receiver, checks address/command integrity and
//  maps remote keys to a 6-digit BCD entry buffer. Buffer nibbles feed the six fnd_dec
//  instances ahead of led_disp. Key-hold detection suppresses repeated entry while held.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency in Hz
//  HOLD_MS     120         key-hold window in ms, restarted by each accepted frame
//  EXP_ADDR    8'h00       required address byte
//  CHK_ADDR    1           1: address byte must equal EXP_ADDR; 0: address not checked
// PORTS
//  clk          in   1   system clock (50 MHz)
//  rst          in   1   asynchronous reset, active-high
//  i_frame      in   32  {addr[31:24], ~addr[23:16], cmd[15:8], ~cmd[7:0]}
//  i_frame_vld  in   1   1-cycle strobe: i_frame holds a new frame
//  o_digits     out  24  6 BCD digits; [3:0] is the newest/rightmost digit
//  o_len        out  3   number of digits entered, 0..6
//  o_key_vld    out  1   1-cycle pulse: new key accepted
//  o_key_rep    out  1   1-cycle pulse: same key re-received inside the hold window
//  o_cmd        out  8   command byte of the last accepted frame
//  o_err_cnt    out  8   count of rejected frames, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> IDLE; hold timer 0; digit buffer all zero.
//  FSM: IDLE, CHECK, APPLY, HOLD.
//   IDLE : on i_frame_vld, latch i_frame -> CHECK.
//   CHECK: good = (addr^naddr)==8'hFF && (cmd^ncmd)==8'hFF && (!CHK_ADDR || addr==EXP_ADDR).
//          If bad: o_err_cnt += 1 (saturating) -> IDLE, or -> HOLD if a hold window was open.
//          If good and cmd==o_cmd with a hold window open: o_key_rep=1, restart timer -> HOLD.
//          Otherwise -> APPLY.
//   APPLY: o_cmd<=cmd; o_key_vld=1; edit buffer; timer<=0 -> HOLD.
//   HOLD : timer += 1 each clk; at HOLD_CYC-1 -> IDLE (window closed). i_frame_vld -> latch
//          frame -> CHECK with window open.
//  HOLD_CYC = CLK_HZ/1000*HOLD_MS (6_000_000 by default); timer 32-bit.
//  Latency: i_frame_vld at cycle N -> o_key_vld at N+2 (APPLY) or o_key_rep at N+1 (CHECK).
//  o_digits/o_len/o_cmd update on the same edge as the o_key_vld pulse.
//  i_frame_vld in CHECK or APPLY is dropped (not counted as an error).
//  Key map (cmd): 16->0, 0C->1, 18->2, 5E->3, 08->4, 1C->5, 5A->6, 42->7, 52->8, 4A->9,
//   44=backspace, 40=clear. Other good cmds: o_key_vld pulse, o_cmd updated, buffer untouched.
//  Digit: o_digits <= {o_digits[19:0], d}; o_len <= min(o_len+1, 6); oldest digit is lost at 6.
//  Backspace: o_digits <= {4'h0, o_digits[23:4]}; o_len <= max(o_len-1, 0); no-op when o_len==0.
//  Clear: o_digits <= 0, o_len <= 0.
//  o_key_vld and o_key_rep are never high on the same cycle.
//  rst asserted in any state: immediate return to reset values; the open frame is discarded.
// TESTING
//  T1 reset: rst high for 3 clk -> all outputs 0; no pulses for 100 clk with i_frame_vld=0.
//  T2 good key: frame 32'h00FF_18E7 -> o_key_vld at N+2, o_cmd=8'h18, o_digits=24'h000002,
//     o_len=1.
//  T3 bad check: frame 32'h00FF_18E6 -> no o_key_vld; o_err_cnt=1; buffer unchanged.
//     Also test CHK_ADDR=1 with frame 32'h01FE_18E7.
//  T4 overflow: keys 1..7, each >HOLD_MS apart -> o_digits=24'h234567, o_len=6.
//     Then backspace (00FF_44BB) -> 24'h023456, o_len=5. Then clear (00FF_40BF) -> 0, o_len=0.
//  T5 hold: 00FF_18E7 twice 50 ms apart -> one o_key_vld then one o_key_rep, o_len=1.
//     Same frame 130 ms later -> o_key_vld, o_digits=24'h000022.
//  T6 reset mid-op: assert rst in CHECK and again in HOLD -> outputs return to 0 at once.
//     The next good frame behaves as in T2.

Source files
------------

// File: rtl/ir_key_decoder.sv
// NEC remote key decoder: validates 32-bit frames, maps keys onto a 6-digit BCD entry
// buffer and suppresses repeated entry while the same key is held.
module ir_key_decoder #(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         HOLD_MS  = 120,
    parameter logic [7:0] EXP_ADDR = 8'h00,
    parameter bit         CHK_ADDR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_frame,
    input  logic        i_frame_vld,
    output logic [23:0] o_digits,
    output logic [2:0]  o_len,
    output logic        o_key_vld,
    output logic        o_key_rep,
    output logic [7:0]  o_cmd,
    output logic [7:0]  o_err_cnt
);

    localparam logic [31:0] HOLD_CYC  = 32'(CLK_HZ / 1000 * HOLD_MS);
    localparam logic [31:0] HOLD_LAST = HOLD_CYC - 32'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_APPLY,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        K_OTHER,
        K_DIGIT,
        K_BKSP,
        K_CLR
    } key_kind_t;

    state_t      state_reg,  state_next;
    logic [31:0] frame_reg,  frame_next;
    logic        win_reg,    win_next;
    logic [31:0] timer_reg,  timer_next;
    logic [23:0] digits_reg, digits_next;
    logic [2:0]  len_reg,    len_next;
    logic [7:0]  cmd_reg,    cmd_next;
    logic [7:0]  err_reg,    err_next;

    logic [7:0]  f_addr, f_naddr, f_cmd, f_ncmd;
    logic        frame_good;
    key_kind_t   key_kind;
    logic [3:0]  key_digit;
    logic        key_vld_c, key_rep_c;

    assign {f_addr, f_naddr, f_cmd, f_ncmd} = frame_reg;

    assign frame_good = ((f_addr ^ f_naddr) == 8'hFF) &&
                        ((f_cmd ^ f_ncmd) == 8'hFF) &&
                        (!CHK_ADDR || (f_addr == EXP_ADDR));

    // Remote key map for the latched command byte
    always_comb begin
        key_kind  = K_OTHER;
        key_digit = 4'd0;
        case (f_cmd)
            8'h16: begin key_kind = K_DIGIT; key_digit = 4'd0; end
            8'h0C: begin key_kind = K_DIGIT; key_digit = 4'd1; end
            8'h18: begin key_kind = K_DIGIT; key_digit = 4'd2; end
            8'h5E: begin key_kind = K_DIGIT; key_digit = 4'd3; end
            8'h08: begin key_kind = K_DIGIT; key_digit = 4'd4; end
            8'h1C: begin key_kind = K_DIGIT; key_digit = 4'd5; end
            8'h5A: begin key_kind = K_DIGIT; key_digit = 4'd6; end
            8'h42: begin key_kind = K_DIGIT; key_digit = 4'd7; end
            8'h52: begin key_kind = K_DIGIT; key_digit = 4'd8; end
            8'h4A: begin key_kind = K_DIGIT; key_digit = 4'd9; end
            8'h44: key_kind = K_BKSP;
            8'h40: key_kind = K_CLR;
            default: ;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        frame_next  = frame_reg;
        win_next    = win_reg;
        timer_next  = timer_reg;
        digits_next = digits_reg;
        len_next    = len_reg;
        cmd_next    = cmd_reg;
        err_next    = err_reg;
        key_vld_c   = 1'b0;
        key_rep_c   = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (i_frame_vld) begin
                    frame_next = i_frame;
                    win_next   = 1'b0;
                    state_next = S_CHECK;
                end
            end

            S_CHECK: begin
                if (!frame_good) begin
                    if (err_reg != 8'hFF) begin
                        err_next = err_reg + 8'd1;
                    end
                    // A bad frame does not disturb an open hold window
                    state_next = win_reg ? S_HOLD : S_IDLE;
                end else if (win_reg && (f_cmd == cmd_reg)) begin
                    key_rep_c  = 1'b1;
                    timer_next = 32'd0;
                    state_next = S_HOLD;
                end else begin
                    state_next = S_APPLY;
                end
            end

            S_APPLY: begin
                key_vld_c  = 1'b1;
                cmd_next   = f_cmd;
                timer_next = 32'd0;
                state_next = S_HOLD;
                case (key_kind)
                    K_DIGIT: begin
                        digits_next = {digits_reg[19:0], key_digit};
                        len_next    = (len_reg == 3'd6) ? 3'd6 : len_reg + 3'd1;
                    end
                    K_BKSP: begin
                        if (len_reg != 3'd0) begin
                            digits_next = {4'h0, digits_reg[23:4]};
                            len_next    = len_reg - 3'd1;
                        end
                    end
                    K_CLR: begin
                        digits_next = 24'h0;
                        len_next    = 3'd0;
                    end
                    default: ;
                endcase
            end

            S_HOLD: begin
                if (i_frame_vld) begin
                    frame_next = i_frame;
                    win_next   = 1'b1;
                    state_next = S_CHECK;
                end else if (timer_reg >= HOLD_LAST) begin
                    timer_next = 32'd0;
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer_reg + 32'd1;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            frame_reg  <= 32'h0;
            win_reg    <= 1'b0;
            timer_reg  <= 32'd0;
            digits_reg <= 24'h0;
            len_reg    <= 3'd0;
            cmd_reg    <= 8'h0;
            err_reg    <= 8'h0;
        end else begin
            state_reg  <= state_next;
            frame_reg  <= frame_next;
            win_reg    <= win_next;
            timer_reg  <= timer_next;
            digits_reg <= digits_next;
            len_reg    <= len_next;
            cmd_reg    <= cmd_next;
            err_reg    <= err_next;
        end
    end

    assign o_digits  = digits_reg;
    assign o_len     = len_reg;
    assign o_cmd     = cmd_reg;
    assign o_err_cnt = err_reg;
    assign o_key_vld = key_vld_c;
    assign o_key_rep = key_rep_c;

endmodule

// File: tb/tb_ir_key_decoder.sv
// Directed plus randomized frames for ir_key_decoder, checked against a digit-list model
// with a time-based hold window.
module tb_ir_key_decoder;

    localparam int CLK_HZ    = 10_000;
    localparam int HOLD_MS   = 120;
    localparam int CYC_MS    = CLK_HZ / 1000;
    localparam int HOLD_CYC  = CYC_MS * HOLD_MS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_frame = 32'h0;
    logic        i_frame_vld = 1'b0;
    logic [23:0] o_digits;
    logic [2:0]  o_len;
    logic        o_key_vld;
    logic        o_key_rep;
    logic [7:0]  o_cmd;
    logic [7:0]  o_err_cnt;

    ir_key_decoder #(
        .CLK_HZ  (CLK_HZ),
        .HOLD_MS (HOLD_MS),
        .EXP_ADDR(8'h00),
        .CHK_ADDR(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_frame    (i_frame),
        .i_frame_vld(i_frame_vld),
        .o_digits   (o_digits),
        .o_len      (o_len),
        .o_key_vld  (o_key_vld),
        .o_key_rep  (o_key_rep),
        .o_cmd      (o_cmd),
        .o_err_cnt  (o_err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int rep_cnt = 0;
    int both_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (o_key_vld) vld_cnt++;
        if (o_key_rep) rep_cnt++;
        if (o_key_vld && o_key_rep) both_cnt++;
    end

    // Reference model: list of entered digits (oldest first) plus last key and error count
    logic [7:0] key_codes [10] = '{8'h16, 8'h0C, 8'h18, 8'h5E, 8'h08,
                                   8'h1C, 8'h5A, 8'h42, 8'h52, 8'h4A};
    int         m_digs[$];
    logic [7:0] m_cmd = 8'h0;
    logic [7:0] m_err = 8'h0;
    bit         m_any = 1'b0;
    int         m_last = 0;
    logic [31:0] last_good = 32'h00FF_18E7;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int key_of(input logic [7:0] c);
        for (int i = 0; i < 10; i++) begin
            if (key_codes[i] == c) return i;
        end
        if (c == 8'h44) return 10;
        if (c == 8'h40) return 11;
        return -1;
    endfunction

    function automatic logic [23:0] model_digits();
        logic [23:0] r = 24'h0;
        foreach (m_digs[i]) r = {r[19:0], 4'(m_digs[i])};
        return r;
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {a, ~a, c, ~c};
    endfunction

    task automatic model_reset();
        m_digs.delete();
        m_cmd = 8'h0;
        m_err = 8'h0;
        m_any = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] f, input string name);
        logic [7:0] a, na, c, nc;
        bit   good, win, exp_vld, exp_rep;
        logic s_rep, s_vld0, s_vld, s_rep1;
        int   v0, r0, k;
        // stay clear of the exact window-closing instant
        while (m_any && (cyc - m_last) >= HOLD_CYC - 20 && (cyc - m_last) <= HOLD_CYC + 20)
            @(negedge clk);
        {a, na, c, nc} = f;
        good = ((a ^ na) == 8'hFF) && ((c ^ nc) == 8'hFF) && (a == 8'h00);
        @(negedge clk);
        win     = m_any && ((cyc - m_last) < HOLD_CYC);
        exp_rep = good && win && (c == m_cmd);
        exp_vld = good && !exp_rep;
        v0 = vld_cnt;
        r0 = rep_cnt;
        i_frame     = f;
        i_frame_vld = 1'b1;
        @(posedge clk); #1;
        i_frame_vld = 1'b0;
        s_rep  = o_key_rep;
        s_vld0 = o_key_vld;
        @(posedge clk); #1;
        s_vld  = o_key_vld;
        s_rep1 = o_key_rep;
        repeat (3) @(posedge clk);
        #1;
        if (!good) begin
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end else begin
            m_any  = 1'b1;
            m_last = cyc;
            last_good = f;
            if (exp_vld) begin
                m_cmd = c;
                k = key_of(c);
                if (k >= 0 && k < 10) begin
                    m_digs.push_back(k);
                    if (m_digs.size() > 6) void'(m_digs.pop_front());
                end else if (k == 10) begin
                    if (m_digs.size() > 0) void'(m_digs.pop_back());
                end else if (k == 11) begin
                    m_digs.delete();
                end
            end
        end
        $display("[TB] %s frame=%08h vld=%0d rep=%0d digits=%06h len=%0d cmd=%02h err=%0d",
                 name, f, s_vld, s_rep, o_digits, o_len, o_cmd, o_err_cnt);
        check({name, " rep@check"}, 32'(s_rep), 32'(exp_rep));
        check({name, " vld@check"}, 32'(s_vld0), 32'd0);
        check({name, " vld@apply"}, 32'(s_vld), 32'(exp_vld));
        check({name, " rep@apply"}, 32'(s_rep1), 32'd0);
        check({name, " vld count"}, 32'(vld_cnt - v0), 32'(exp_vld));
        check({name, " rep count"}, 32'(rep_cnt - r0), 32'(exp_rep));
        check({name, " digits"}, 32'(o_digits), 32'(model_digits()));
        check({name, " len"}, 32'(o_len), 32'(m_digs.size()));
        check({name, " cmd"}, 32'(o_cmd), 32'(m_cmd));
        check({name, " err"}, 32'(o_err_cnt), 32'(m_err));
    endtask

    task automatic check_zero(input string name);
        check({name, " digits"}, 32'(o_digits), 32'd0);
        check({name, " len"}, 32'(o_len), 32'd0);
        check({name, " cmd"}, 32'(o_cmd), 32'd0);
        check({name, " err"}, 32'(o_err_cnt), 32'd0);
        check({name, " vld"}, 32'(o_key_vld), 32'd0);
        check({name, " rep"}, 32'(o_key_rep), 32'd0);
    endtask

    initial begin
        logic [7:0] seq_keys [7] = '{8'h0C, 8'h18, 8'h5E, 8'h08, 8'h1C, 8'h5A, 8'h42};
        logic [31:0] f;
        int r;

        // T1: reset held for 3 clocks, then idle for 100 clocks
        repeat (3) @(posedge clk);
        #1;
        check_zero("T1 in reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_cyc(100);
        check_zero("T1 idle");
        check("T1 vld pulses", 32'(vld_cnt), 32'd0);
        check("T1 rep pulses", 32'(rep_cnt), 32'd0);

        // T2: one good key
        send(32'h00FF_18E7, "T2 key2");
        check("T2 digits const", 32'(o_digits), 32'h000002);
        check("T2 len const", 32'(o_len), 32'd1);
        check("T2 cmd const", 32'(o_cmd), 32'h18);

        // T3: integrity failures
        wait_cyc(20);
        send(32'h00FF_18E6, "T3 badcmd");
        check("T3 err const", 32'(o_err_cnt), 32'd1);
        check("T3 digits kept", 32'(o_digits), 32'h000002);
        wait_cyc(20);
        send(32'h01FE_18E7, "T3 badaddr");
        check("T3 err2 const", 32'(o_err_cnt), 32'd2);

        // T4: overflow, backspace, clear
        wait_cyc(HOLD_CYC + 100);
        send(32'h00FF_40BF, "T4 preclear");
        for (int i = 0; i < 7; i++) begin
            wait_cyc(13 * HOLD_CYC / 12);
            send(mk(8'h00, seq_keys[i]), "T4 key");
        end
        check("T4 digits const", 32'(o_digits), 32'h234567);
        check("T4 len const", 32'(o_len), 32'd6);
        wait_cyc(HOLD_CYC + 100);
        send(32'h00FF_44BB, "T4 bksp");
        check("T4 bksp digits", 32'(o_digits), 32'h023456);
        check("T4 bksp len", 32'(o_len), 32'd5);
        wait_cyc(HOLD_CYC + 100);
        send(32'h00FF_40BF, "T4 clear");
        check("T4 clear digits", 32'(o_digits), 32'h0);
        check("T4 clear len", 32'(o_len), 32'd0);

        // T5: key hold
        wait_cyc(HOLD_CYC + 100);
        send(32'h00FF_18E7, "T5 first");
        wait_cyc(50 * CYC_MS);
        send(32'h00FF_18E7, "T5 held");
        check("T5 len after hold", 32'(o_len), 32'd1);
        wait_cyc(130 * CYC_MS);
        send(32'h00FF_18E7, "T5 again");
        check("T5 digits const", 32'(o_digits), 32'h000022);

        // Randomized frames with short and long gaps
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) wait_cyc($urandom_range(HOLD_CYC + 40, HOLD_CYC + 300));
            else                           wait_cyc($urandom_range(5, HOLD_CYC / 2));
            r = $urandom_range(0, 11);
            if (r == 0)       f = mk(8'h00, 8'($urandom_range(0, 255))) ^ (32'h1 << $urandom_range(0, 31));
            else if (r == 1)  f = mk(8'($urandom_range(1, 255)), key_codes[$urandom_range(0, 9)]);
            else if (r == 2)  f = mk(8'h00, 8'($urandom_range(0, 255)));
            else if (r == 3)  f = mk(8'h00, ($urandom_range(0, 3) == 0) ? 8'h40 : 8'h44);
            else if (r >= 9)  f = last_good;
            else              f = mk(8'h00, key_codes[$urandom_range(0, 9)]);
            send(f, "RND");
        end

        // T6: reset while in CHECK, then while in HOLD
        wait_cyc(HOLD_CYC + 100);
        send(32'h00FF_0CF3, "T6 prep");
        send(32'h00FF_0CF2, "T6 preperr");
        wait_cyc(HOLD_CYC + 100);
        @(negedge clk);
        i_frame     = 32'h00FF_5EA1;
        i_frame_vld = 1'b1;
        @(posedge clk); #1;
        i_frame_vld = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_zero("T6 rst@check");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_cyc(5);
        check_zero("T6 after check rst");
        send(32'h00FF_5EA1, "T6 prep2");
        wait_cyc(10);
        #2 rst = 1'b1;
        #1;
        check_zero("T6 rst@hold");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_cyc(5);
        send(32'h00FF_18E7, "T6 key2");
        check("T6 digits const", 32'(o_digits), 32'h000002);
        check("T6 len const", 32'(o_len), 32'd1);
        check("T6 cmd const", 32'(o_cmd), 32'h18);

        wait_cyc(10);
        check("vld/rep exclusive", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
